regfile_seq: RTL

REGFILE_SEQ -- requirements
Module: regfile_seq

---
 rtl/regfile_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/regfile_seq.sv
// Sequencer that turns one read-read-(write) request into accesses on a single-port register file.
// Optional build macro REGFILE_SEQ_SKIP_X0_EN skips reads of x0 and returns 0 for them.
module regfile_seq #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  input  logic [AW-1:0]   req_rd,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rs1_data,
  output logic [XLEN-1:0] rsp_rs2_data,
  output logic [AW-1:0]   rf_addr,
  output logic [XLEN-1:0] rf_in,
  output logic            rf_write,
  input  logic [XLEN-1:0] rf_out
);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR,
    RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [AW-1:0]   r_rs1;
  logic [AW-1:0]   r_rs2;
  logic [AW-1:0]   r_rd;
  logic            r_we;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;

  logic            w_accept;
  logic            w_do_write;

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_do_write = r_we && (r_rd != '0);

  assign req_ready    = (r_state == IDLE);
  assign rsp_valid    = (r_state == RESP);
  assign rsp_rs1_data = r_rs1_data;
  assign rsp_rs2_data = r_rs2_data;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef REGFILE_SEQ_SKIP_X0_EN
          if (req_rs1 != '0)                      w_next = RD1;
          else if (req_rs2 != '0)                 w_next = RD2;
          else if (req_we && (req_rd != '0))      w_next = WR;
          else                                    w_next = RESP;
`else
          w_next = RD1;
`endif
        end
      end
      RD1: begin
`ifdef REGFILE_SEQ_SKIP_X0_EN
        if (r_rs2 != '0)      w_next = RD2;
        else if (w_do_write)  w_next = WR;
        else                  w_next = RESP;
`else
        w_next = RD2;
`endif
      end
      RD2:     w_next = w_do_write ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The register-file port is parked at x0 with no write outside the access states.
  always_comb begin
    rf_addr  = '0;
    rf_in    = '0;
    rf_write = 1'b0;
    unique case (r_state)
      RD1: rf_addr = r_rs1;
      RD2: rf_addr = r_rs2;
      WR: begin
        rf_addr  = r_rd;
        rf_in    = r_wdata;
        rf_write = !rst && (r_rd != '0);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rs1      <= req_rs1;
        r_rs2      <= req_rs2;
        r_rd       <= req_rd;
        r_we       <= req_we;
        r_wdata    <= req_wdata;
        // Results start at 0 so a skipped x0 read returns 0.
        r_rs1_data <= '0;
        r_rs2_data <= '0;
      end
      if (r_state == RD1) r_rs1_data <= rf_out;
      if (r_state == RD2) r_rs2_data <= rf_out;
    end
  end

endmodule
